digit_scan_ctrl: RTL



---
 rtl/scan_pkg.sv | 30 +++
 rtl/next_digit_finder.sv | 36 +++
 rtl/digit_scan_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared state encoding and width/polarity helpers for the multiplexed
// display scan controller.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++)
      if ((1 << r) >= v) return r;
    return 31;
  endfunction

  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Wide enough to hold the longer of the two dwell lengths.
  function automatic int cnt_width(input int tick_div, input int blank_cycles);
    return clog2(((tick_div > blank_cycles) ? tick_div : blank_cycles) + 1);
  endfunction

  function automatic logic anode_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/next_digit_finder.sv
// Combinational search over the digit mask: lowest set index and the next
// set index above the current one, wrapping to the lowest.
module next_digit_finder #(
  parameter int NUM_DIGITS = 7,
  parameter int SEL_W      = scan_pkg::sel_width(NUM_DIGITS)
) (
  input  logic [SEL_W-1:0]      cur,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_W-1:0]      next_idx,
  output logic [SEL_W-1:0]      lowest_idx,
  output logic                  valid
);

  logic             found_up;
  logic [SEL_W-1:0] up_idx;

  always_comb begin
    lowest_idx = '0;
    valid      = 1'b0;
    up_idx     = '0;
    found_up   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (mask[i] && !valid) begin
        lowest_idx = SEL_W'(i);
        valid      = 1'b1;
      end
      if (mask[i] && !found_up && (i > int'(cur))) begin
        up_idx   = SEL_W'(i);
        found_up = 1'b1;
      end
    end
  end

  assign next_idx = found_up ? up_idx : lowest_idx;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scan: one-hot anode drive with per-digit dwell,
// dead-time blanking between digits, enable mask with skip, frame strobe.
module digit_scan_ctrl import scan_pkg::*; #(
  parameter int NUM_DIGITS       = 7,
  parameter int TICK_DIV         = 100000,
  parameter int BLANK_CYCLES     = 1000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEL_W            = sel_width(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int            CW        = cnt_width(TICK_DIV, BLANK_CYCLES);
  localparam logic [CW-1:0] TICK_LD   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LD  = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic          ACT_LO    = (ANODE_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACT_LO}};

  function automatic logic [NUM_DIGITS-1:0] drive(input logic [SEL_W-1:0] idx);
    logic [NUM_DIGITS-1:0] a;
    for (int i = 0; i < NUM_DIGITS; i++)
      a[i] = anode_level(SEL_W'(i) == idx, ACT_LO);
    return a;
  endfunction

  scan_state_e      state;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] nxt_idx;
  logic [SEL_W-1:0] low_idx;
  logic             any_en;
  logic             leave_on;
  logic [SEL_W-1:0] tgt;

  next_digit_finder #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEL_W      (SEL_W)
  ) u_finder (
    .cur        (digit_sel),
    .mask       (digit_mask),
    .next_idx   (nxt_idx),
    .lowest_idx (low_idx),
    .valid      (any_en)
  );

  // Dwell expiry and a mask bit dropped under the lit digit both end the slot.
  assign leave_on = (state == ST_ON) && ((cnt == '0) || !digit_mask[digit_sel]);
  assign tgt      = (state == ST_IDLE) ? low_idx : nxt_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      digit_sel   <= '0;
      anode       <= ANODE_OFF;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      cnt         <= '0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        digit_sel <= '0;
        anode     <= ANODE_OFF;
        blank     <= 1'b1;
        cnt       <= '0;
      end else if (!any_en) begin
        // Empty mask parks in IDLE but keeps the last selected index.
        state <= ST_IDLE;
        anode <= ANODE_OFF;
        blank <= 1'b1;
        cnt   <= '0;
      end else if (state == ST_IDLE || leave_on) begin
        digit_sel <= tgt;
        if (BLANK_CYCLES == 0) begin
          state       <= ST_ON;
          anode       <= drive(tgt);
          blank       <= 1'b0;
          cnt         <= TICK_LD;
          frame_start <= (tgt == low_idx);
        end else begin
          state <= ST_BLANK;
          anode <= ANODE_OFF;
          blank <= 1'b1;
          cnt   <= BLANK_LD;
        end
      end else if (state == ST_BLANK && cnt == '0) begin
        state       <= ST_ON;
        anode       <= drive(digit_sel);
        blank       <= 1'b0;
        cnt         <= TICK_LD;
        frame_start <= (digit_sel == low_idx);
      end else if (state == ST_BLANK || state == ST_ON) begin
        cnt <= cnt - 1'b1;
      end else begin
        state <= ST_IDLE;
        anode <= ANODE_OFF;
        blank <= 1'b1;
        cnt   <= '0;
      end
    end
  end

endmodule
